// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Purpose:
//   Accepts (a, b, op) commands from upstream agents, buffers them in a small
//   FIFO and issues them one at a time to a 4-bit ALU. Once the ALU latency
//   has elapsed, it captures the ALU result and returns it over a valid/ready
//   response interface, tagged with the opcode and a 4-bit sequence number.
//   Reserved opcodes (101-111) are not issued to the ALU. They produce an
//   error response with a zero result.
//
// Parameters:
//   DEPTH    command FIFO entries (power of two, >= 2)
//   ALU_LAT  cycles from an ALU input change to a valid alu_result
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   cmd_valid   command present
//   cmd_ready   FIFO can accept a command (not full)
//   cmd_a/b     4-bit operands
//   cmd_op      3-bit opcode (000 add, 001 sub, 010 and, 011 or, 100 not a)
//   alu_a/b/op  registered drive to the ALU, held until the next issue
//   alu_result  result returned by the ALU
//   rsp_valid   response present
//   rsp_ready   downstream accepts the response
//   rsp_result  captured ALU result (0 on error)
//   rsp_op      opcode of this response
//   rsp_err     reserved opcode was rejected
//   rsp_seq     number of responses handshaken since reset, modulo 16
//   busy        FIFO non-empty or a command in flight
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_op,
  output logic       rsp_err,
  output logic [3:0] rsp_seq,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The wait counter must hold ALU_LAT; keep at least one bit for ALU_LAT = 0.
  localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(ALU_LAT);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO. An entry is packed as {op, b, a}.
  // ---------------------------------------------------------------------------
  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [10:0]   head;
  logic [3:0]    head_a;
  logic [3:0]    head_b;
  logic [2:0]    head_op;
  logic          head_reserved;

  // FSM and output registers
  state_t        state_q;
  logic [CW-1:0] wait_cnt_q;
  logic [3:0]    alu_a_q;
  logic [3:0]    alu_b_q;
  logic [2:0]    alu_op_q;
  logic          rsp_valid_q;
  logic [3:0]    rsp_result_q;
  logic [2:0]    rsp_op_q;
  logic          rsp_err_q;
  logic [3:0]    seq_q;

  assign full      = (count_q == FULL_CNT);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // The head entry is consumed only when the FSM is free to start on it.
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  // The head is read combinationally so that IDLE can pop and issue on the
  // same edge. The FIFO is small enough to live in registers.
  assign head          = mem_q[rd_ptr_q];
  assign head_a        = head[3:0];
  assign head_b        = head[7:4];
  assign head_op       = head[10:8];
  assign head_reserved = (head_op > 3'b100);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A simultaneous push and pop leaves the occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset. Validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
    end
  end

  // ---------------------------------------------------------------------------
  // Issue / collect FSM. All outputs are registered here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
      seq_q        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            rsp_op_q <= head_op;
            if (head_reserved) begin
              // Never reaches the ALU. The last issued operands stay on the bus.
              rsp_result_q <= '0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_HOLD;
            end else begin
              alu_a_q    <= head_a;
              alu_b_q    <= head_b;
              alu_op_q   <= head_op;
              wait_cnt_q <= LAT_LOAD;
              state_q    <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          // ALU_LAT decrements, then one capture cycle. The ALU has seen
          // the operands for ALU_LAT edges by the time alu_result is sampled.
          if (wait_cnt_q == '0) begin
            rsp_result_q <= alu_result;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end

        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            seq_q       <= seq_q + 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_seq    = seq_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule
